tt_um_csit_luks: RTL and testbench

TT_UM_CSIT_LUKS -- requirements
Module: tt_um_csit_luks

---
 rtl/tt_um_csit_luks.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_tt_um_csit_luks.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_csit_luks.sv
// Exposure-meter front end: quadrature encoder and debounced button select ISO/shutter/aperture
// indices, and EXP_METER reads one calibration byte from SPI flash. Define LUKS_SPI_WAKE_EN to send a 0xAB wake frame first.
module tt_um_csit_luks #(
    parameter int unsigned DEB_CYC = 8,
    parameter int unsigned MED_CYC = 256,
    parameter int unsigned ISO_MAX = 7,
    parameter int unsigned SS_MAX  = 15,
    parameter int unsigned F_MAX   = 11,
    parameter int unsigned F_RST   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {ISO_SEL, SS_SEL, F_SEL, EXP_METER} mode_e;
    typedef enum logic [1:0] {SPI_IDLE, SPI_XFER, SPI_GAP} spi_e;

    localparam int DBW = $clog2(DEB_CYC + 1);
    localparam int PCW = $clog2(MED_CYC + 1);

    logic [2:0]     sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]     ab_prev_q, ab_prev_d;
    logic [DBW-1:0] deb_cnt_q, deb_cnt_d;
    logic           btn_q, btn_d;
    logic [PCW-1:0] press_cnt_q, press_cnt_d;
    mode_e          mode_q, mode_d;
    logic [2:0]     iso_q, iso_d;
    logic [3:0]     ss_q, ss_d;
    logic [3:0]     f_q, f_d;
    spi_e           spi_q, spi_d;
    logic [39:0]    tx_q, tx_d;
    logic [5:0]     bit_q, bit_d;
    logic [5:0]     last_q, last_d;
    logic           rd_frame_q, rd_frame_d;
    logic           rd_pend_q, rd_pend_d;
    logic           gap_q, gap_d;
    logic           sck_q, sck_d;
    logic           csb_q, csb_d;
    logic           mosi_q, mosi_d;
    logic [7:0]     rx_q, rx_d;
    logic [7:0]     result_q, result_d;
    logic [7:0]     uo_q, uo_d;
    logic           wake_pend_q, wake_pend_d;

    logic [1:0]  ab_s;
    logic        btn_raw_s, step_up_s, step_dn_s, rel_s, short_s, med_s;
    logic        busy_s, start_s, start_frame_s, use_wake_s;
    logic [39:0] load_s;
    logic [7:0]  rx_next_s;
    logic        unused_s;

    assign unused_s = &{1'b0, ena, uio_in, ui_in[7:4]};

    // Input synchronizers, encoder edge detection and button debouncing/classification
    always_comb begin
        sync1_d   = ui_in[2:0];
        sync2_d   = sync1_q;
        ab_s      = {sync2_q[0], sync2_q[1]};
        btn_raw_s = ~sync2_q[2];
        ab_prev_d = ab_s;
        step_up_s = (ab_s == 2'b00) && (ab_prev_q == 2'b01);
        step_dn_s = (ab_s == 2'b00) && (ab_prev_q == 2'b10);

        btn_d     = btn_q;
        deb_cnt_d = {DBW{1'b0}};
        if (btn_raw_s != btn_q) begin
            if (deb_cnt_q == DBW'(DEB_CYC - 1)) begin
                btn_d = btn_raw_s;
            end else begin
                deb_cnt_d = deb_cnt_q + DBW'(1);
            end
        end else begin
            deb_cnt_d = {DBW{1'b0}};
        end

        if (!btn_q && btn_d) begin
            press_cnt_d = {PCW{1'b0}};
        end else if (btn_q && (press_cnt_q != PCW'(MED_CYC))) begin
            press_cnt_d = press_cnt_q + PCW'(1);
        end else begin
            press_cnt_d = press_cnt_q;
        end

        rel_s   = btn_q && !btn_d;
        short_s = rel_s && (press_cnt_q < PCW'(MED_CYC));
        med_s   = rel_s && (press_cnt_q >= PCW'(MED_CYC));
    end

    assign busy_s = (spi_q != SPI_IDLE);

    // Mode FSM and saturating index adjustment; presses are dropped while flash is busy
    always_comb begin
        mode_d  = mode_q;
        iso_d   = iso_q;
        ss_d    = ss_q;
        f_d     = f_q;
        start_s = 1'b0;
        if (!busy_s && med_s && (mode_q != EXP_METER)) begin
            mode_d  = EXP_METER;
            start_s = 1'b1;
        end else if (!busy_s && med_s) begin
            mode_d = ISO_SEL;
        end else if (!busy_s && short_s) begin
            case (mode_q)
                ISO_SEL:   mode_d = SS_SEL;
                SS_SEL:    mode_d = F_SEL;
                F_SEL:     mode_d = ISO_SEL;
                EXP_METER: start_s = 1'b1;
                default:   mode_d = ISO_SEL;
            endcase
        end else begin
            mode_d = mode_q;
        end

        case (mode_q)
            ISO_SEL: begin
                if (step_up_s && (iso_q != 3'(ISO_MAX))) begin
                    iso_d = iso_q + 3'd1;
                end else if (step_dn_s && (iso_q != 3'd0)) begin
                    iso_d = iso_q - 3'd1;
                end else begin
                    iso_d = iso_q;
                end
            end
            SS_SEL: begin
                if (step_up_s && (ss_q != 4'(SS_MAX))) begin
                    ss_d = ss_q + 4'd1;
                end else if (step_dn_s && (ss_q != 4'd0)) begin
                    ss_d = ss_q - 4'd1;
                end else begin
                    ss_d = ss_q;
                end
            end
            F_SEL: begin
                if (step_up_s && (f_q != 4'(F_MAX))) begin
                    f_d = f_q + 4'd1;
                end else if (step_dn_s && (f_q != 4'd0)) begin
                    f_d = f_q - 4'd1;
                end else begin
                    f_d = f_q;
                end
            end
            default: begin
                iso_d = iso_q;
            end
        endcase
    end

`ifdef LUKS_SPI_WAKE_EN
    assign use_wake_s = wake_pend_q;
`else
    assign use_wake_s = 1'b0;
`endif

    assign load_s        = use_wake_s ? {8'hAB, 32'h0000_0000}
                                      : {8'h03, 12'h000, 1'b0, iso_q, ss_q, f_q, 8'h00};
    assign start_frame_s = ((spi_q == SPI_IDLE) && start_s) ||
                           ((spi_q == SPI_GAP) && gap_q && rd_pend_q);
    // MISO is sampled at the end of the SCK high phase, a full clk after the slave's rising edge
    assign rx_next_s     = {rx_q[6:0], ui_in[3]};

    // SPI mode-0 sequencer: one bit per two clk, CSB held high for two clk between frames
    always_comb begin
        spi_d       = spi_q;
        tx_d        = tx_q;
        bit_d       = bit_q;
        last_d      = last_q;
        rd_frame_d  = rd_frame_q;
        rd_pend_d   = rd_pend_q;
        gap_d       = gap_q;
        sck_d       = sck_q;
        csb_d       = csb_q;
        mosi_d      = mosi_q;
        rx_d        = rx_q;
        result_d    = result_q;
        wake_pend_d = wake_pend_q;
        case (spi_q)
            SPI_IDLE: begin
                spi_d = SPI_IDLE;
            end
            SPI_XFER: begin
                if (!sck_q) begin
                    sck_d = 1'b1;
                end else begin
                    sck_d = 1'b0;
                    rx_d  = rx_next_s;
                    if (bit_q == last_q) begin
                        csb_d  = 1'b1;
                        mosi_d = 1'b0;
                        spi_d  = SPI_GAP;
                        gap_d  = 1'b0;
                        if (rd_frame_q) begin
                            result_d = rx_next_s;
                        end else begin
                            result_d = result_q;
                        end
                    end else begin
                        bit_d  = bit_q + 6'd1;
                        tx_d   = {tx_q[38:0], 1'b0};
                        mosi_d = tx_q[38];
                    end
                end
            end
            SPI_GAP: begin
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else if (!rd_pend_q) begin
                    spi_d = SPI_IDLE;
                end else begin
                    spi_d = SPI_GAP;
                end
            end
            default: begin
                spi_d = SPI_IDLE;
                csb_d = 1'b1;
                sck_d = 1'b0;
            end
        endcase

        if (start_frame_s) begin
            spi_d       = SPI_XFER;
            tx_d        = load_s;
            mosi_d      = load_s[39];
            csb_d       = 1'b0;
            sck_d       = 1'b0;
            bit_d       = 6'd0;
            last_d      = use_wake_s ? 6'd7 : 6'd39;
            rd_frame_d  = !use_wake_s;
            rd_pend_d   = use_wake_s;
            wake_pend_d = 1'b0;
        end else begin
            wake_pend_d = wake_pend_d;
        end
    end

    // Display byte is computed from next-state values so the registered output tracks state
    always_comb begin
        uo_d = 8'h00;
        case (mode_d)
            ISO_SEL:   uo_d = {4'h1, 1'b0, iso_d};
            SS_SEL:    uo_d = {4'h2, ss_d};
            F_SEL:     uo_d = {4'h3, f_d};
            EXP_METER: uo_d = result_d;
            default:   uo_d = 8'h00;
        endcase
    end

    // State registers; the reset pin is active-high despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync1_q     <= 3'b100;
            sync2_q     <= 3'b100;
            ab_prev_q   <= 2'b00;
            deb_cnt_q   <= {DBW{1'b0}};
            btn_q       <= 1'b0;
            press_cnt_q <= {PCW{1'b0}};
            mode_q      <= ISO_SEL;
            iso_q       <= 3'd0;
            ss_q        <= 4'd0;
            f_q         <= 4'(F_RST);
            spi_q       <= SPI_IDLE;
            tx_q        <= 40'h00_0000_0000;
            bit_q       <= 6'd0;
            last_q      <= 6'd0;
            rd_frame_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
            gap_q       <= 1'b0;
            sck_q       <= 1'b0;
            csb_q       <= 1'b1;
            mosi_q      <= 1'b0;
            rx_q        <= 8'h00;
            result_q    <= 8'h00;
            uo_q        <= 8'h10;
            wake_pend_q <= 1'b1;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            ab_prev_q   <= ab_prev_d;
            deb_cnt_q   <= deb_cnt_d;
            btn_q       <= btn_d;
            press_cnt_q <= press_cnt_d;
            mode_q      <= mode_d;
            iso_q       <= iso_d;
            ss_q        <= ss_d;
            f_q         <= f_d;
            spi_q       <= spi_d;
            tx_q        <= tx_d;
            bit_q       <= bit_d;
            last_q      <= last_d;
            rd_frame_q  <= rd_frame_d;
            rd_pend_q   <= rd_pend_d;
            gap_q       <= gap_d;
            sck_q       <= sck_d;
            csb_q       <= csb_d;
            mosi_q      <= mosi_d;
            rx_q        <= rx_d;
            result_q    <= result_d;
            uo_q        <= uo_d;
            wake_pend_q <= wake_pend_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = {mosi_q, 1'b0, csb_q, sck_q, 4'b0000};
    assign uio_oe  = 8'b1011_0000;

endmodule

// File: tb/tb_tt_um_csit_luks.sv
// Directed self-checking bench for tt_um_csit_luks with a behavioural SPI flash model
// (byte at address A is A[7:0] + 8'h11). Honours LUKS_SPI_WAKE_EN when defined.
module tb_tt_um_csit_luks;

`ifdef LUKS_SPI_WAKE_EN
    localparam int WAKE_FRAMES = 1;
`else
    localparam int WAKE_FRAMES = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] pins;
    logic       miso;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    assign ui_in = {4'b0000, miso, pins};

    tt_um_csit_luks dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash model
    wire        sck  = uio_out[4];
    wire        csb  = uio_out[5];
    wire        mosi = uio_out[7];
    int         bitcnt;
    logic [39:0] sh;
    logic [7:0] rd_byte;
    logic       in_frame;
    int         n_ab;
    int         n_rd;
    logic [39:0] last_rd;
    time        t_csb_hi;
    time        min_gap;

    initial begin
        bitcnt = 0; sh = '0; rd_byte = 8'h00; in_frame = 1'b0;
        n_ab = 0; n_rd = 0; last_rd = '0; t_csb_hi = 0; min_gap = 1000000; miso = 1'b0;
    end

    always @(negedge csb) begin
        if ((t_csb_hi != 0) && (($time - t_csb_hi) < min_gap)) min_gap = $time - t_csb_hi;
        bitcnt = 0; sh = '0; in_frame = 1'b1;
    end

    always @(posedge csb) begin
        if (in_frame) begin
            t_csb_hi = $time;
            if (bitcnt == 8 && sh[7:0] == 8'hAB) n_ab++;
            if (bitcnt == 40) begin
                n_rd++;
                last_rd = sh;
            end
        end
        in_frame = 1'b0;
    end

    always @(posedge sck) begin
        if (csb === 1'b0) begin
            sh = {sh[38:0], mosi};
            bitcnt++;
            if (bitcnt == 32) rd_byte = sh[7:0] + 8'h11;
        end
    end

    always @(negedge sck) begin
        if (csb === 1'b0 && bitcnt >= 32 && bitcnt < 40) miso = rd_byte[39 - bitcnt];
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic enc_set(input logic [1:0] ab);
        pins[0] = ab[1];
        pins[1] = ab[0];
        cycles(3);
    endtask

    task automatic enc_cw(input int n);
        for (int i = 0; i < n; i++) begin
            enc_set(2'b10); enc_set(2'b11); enc_set(2'b01); enc_set(2'b00);
        end
        cycles(5);
    endtask

    task automatic enc_ccw(input int n);
        for (int i = 0; i < n; i++) begin
            enc_set(2'b01); enc_set(2'b11); enc_set(2'b10); enc_set(2'b00);
        end
        cycles(5);
    endtask

    task automatic press(input int n);
        pins[2] = 1'b0;
        cycles(n);
        pins[2] = 1'b1;
        cycles(30);
    endtask

    task automatic wait_read(input int prev);
        for (int i = 0; i < 800; i++) begin
            if (n_rd > prev) break;
            @(negedge clk);
        end
        cycles(4);
        checks++;
        if (n_rd !== prev + 1) begin
            errors++;
            $display("FAIL read_done: reads=%0d required=%0d", n_rd, prev + 1);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        cycles(3);
        checks++; if (uo_out !== 8'h10) begin errors++; $display("FAIL rst_uo: got %h want 10", uo_out); end
        checks++; if (csb !== 1'b1) begin errors++; $display("FAIL rst_csb: got %b want 1", csb); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b want 0", sck); end
        checks++; if (uio_oe !== 8'hB0) begin errors++; $display("FAIL rst_oe: got %h want b0", uio_oe); end
        checks++; if (uio_out !== 8'h20) begin errors++; $display("FAIL rst_uio: got %h want 20", uio_out); end
        rst_n = 1'b0;
        cycles(5);
    endtask

    task automatic test_iso;
        enc_cw(4);
        checks++; if (uo_out !== 8'h14) begin errors++; $display("FAIL iso_4cw: got %h want 14", uo_out); end
        enc_cw(10);
        checks++; if (uo_out !== 8'h17) begin errors++; $display("FAIL iso_sat: got %h want 17", uo_out); end
    endtask

    task automatic test_ss_f;
        press(100);
        checks++; if (uo_out !== 8'h20) begin errors++; $display("FAIL to_ss: got %h want 20", uo_out); end
        enc_cw(3);
        checks++; if (uo_out !== 8'h23) begin errors++; $display("FAIL ss_3cw: got %h want 23", uo_out); end
        press(100);
        checks++; if (uo_out !== 8'h34) begin errors++; $display("FAIL to_f: got %h want 34", uo_out); end
        enc_ccw(2);
        checks++; if (uo_out !== 8'h32) begin errors++; $display("FAIL f_2ccw: got %h want 32", uo_out); end
    endtask

    task automatic test_iso_down;
        press(100);
        checks++; if (uo_out !== 8'h17) begin errors++; $display("FAIL wrap_iso: got %h want 17", uo_out); end
        enc_ccw(3);
        checks++; if (uo_out !== 8'h14) begin errors++; $display("FAIL iso_3ccw: got %h want 14", uo_out); end
        press(100);
        press(100);
        checks++; if (uo_out !== 8'h32) begin errors++; $display("FAIL back_f: got %h want 32", uo_out); end
    endtask

    task automatic test_meter;
        press(400);
        wait_read(0);
        checks++; if (last_rd !== 40'h03_000432_00) begin errors++; $display("FAIL rd_frame: got %h want 0300043200", last_rd); end
        checks++; if (n_ab !== WAKE_FRAMES) begin errors++; $display("FAIL wake_cnt: got %0d want %0d", n_ab, WAKE_FRAMES); end
        checks++; if (uo_out !== 8'h43) begin errors++; $display("FAIL meter_uo: got %h want 43", uo_out); end
        checks++; if (min_gap < 20) begin errors++; $display("FAIL csb_gap: got %0t want >=20", min_gap); end
    endtask

    task automatic test_back_to_back;
        press(100);
        wait_read(1);
        checks++; if (last_rd !== 40'h03_000432_00) begin errors++; $display("FAIL rd2_frame: got %h want 0300043200", last_rd); end
        checks++; if (n_ab !== WAKE_FRAMES) begin errors++; $display("FAIL wake_once: got %0d want %0d", n_ab, WAKE_FRAMES); end
        checks++; if (uo_out !== 8'h43) begin errors++; $display("FAIL meter2_uo: got %h want 43", uo_out); end
        press(400);
        checks++; if (uo_out !== 8'h14) begin errors++; $display("FAIL exit_meter: got %h want 14", uo_out); end
    endtask

    task automatic test_glitch;
        pins[2] = 1'b0;
        cycles(4);
        pins[2] = 1'b1;
        cycles(30);
        checks++; if (uo_out !== 8'h14) begin errors++; $display("FAIL glitch: got %h want 14", uo_out); end
    endtask

    task automatic test_reset_mid_frame;
        pins[2] = 1'b0;
        cycles(400);
        pins[2] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (csb === 1'b0) break;
            @(negedge clk);
        end
        cycles(10);
        checks++; if (csb !== 1'b0) begin errors++; $display("FAIL mid_frame: csb got %b want 0", csb); end
        rst_n = 1'b1;
        #1;
        checks++; if (csb !== 1'b1) begin errors++; $display("FAIL abort_csb: got %b want 1", csb); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL abort_sck: got %b want 0", sck); end
        checks++; if (uo_out !== 8'h10) begin errors++; $display("FAIL abort_uo: got %h want 10", uo_out); end
        cycles(3);
        rst_n = 1'b0;
        cycles(5);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ena    = 1'b1;
        uio_in = 8'h00;
        pins   = 3'b100;
        rst_n  = 1'b0;
        test_reset;
        test_iso;
        test_ss_f;
        test_iso_down;
        test_meter;
        test_back_to_back;
        test_glitch;
        test_reset_mid_frame;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
